// File: rtl/video_timing_gen_if.sv
// Pixel-rate output bundle of the raster timing generator: sync/DE toward the
// TMDS encoder plus the fetch coordinate stream one cycle ahead of them.
interface video_timing_if #(
    parameter int CW = 12
);
    logic          hsync;
    logic          vsync;
    logic          activeArea;
    logic          fetchValid;
    logic [CW-1:0] fetchX;
    logic [CW-1:0] fetchY;
    logic          frameStart;
    logic          lineStart;

    modport master (
        output hsync, vsync, activeArea, fetchValid, fetchX, fetchY, frameStart, lineStart
    );
    modport slave (
        input  hsync, vsync, activeArea, fetchValid, fetchX, fetchY, frameStart, lineStart
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters, a fetch stage one cycle
// ahead, and a sync/DE stage aligned with a registered pixel source.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 12
) (
    input  logic PClk,
    input  logic Reset,
    input  logic Run,
    video_timing_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Inclusive upper bounds keep every constant representable in CW bits.
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          h_wrap, vis, hs, vs;

    logic          fetch_valid_q;
    logic [CW-1:0] fetch_x_q, fetch_y_q;
    logic          hs1_q, vs1_q;

    logic          active_q, hsync_q, vsync_q, frame_start_q, line_start_q;

    always_comb begin
        h_wrap = (hcnt_q == H_LAST);
        hcnt_d = '0;
        vcnt_d = '0;
        if (Run) begin
            hcnt_d = h_wrap ? '0 : hcnt_q + CW'(1);
            vcnt_d = vcnt_q;
            if (h_wrap) begin
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
            end
        end
        // Gated by Run so a held (zeroed) counter does not look like pixel (0,0).
        vis = Run && (hcnt_q <= H_ACT_LAST) && (vcnt_q <= V_ACT_LAST);
        hs  = Run && (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST);
        vs  = Run && (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST);
    end

    always_ff @(posedge PClk or negedge Reset) begin
        if (!Reset) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            fetch_valid_q <= 1'b0;
            fetch_x_q     <= '0;
            fetch_y_q     <= '0;
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            active_q      <= 1'b0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            fetch_valid_q <= vis;
            fetch_x_q     <= vis ? hcnt_q : '0;
            fetch_y_q     <= vis ? vcnt_q : '0;
            hs1_q         <= hs;
            vs1_q         <= vs;
            active_q      <= fetch_valid_q;
            hsync_q       <= ~(hs1_q ^ H_POL);
            vsync_q       <= ~(vs1_q ^ V_POL);
            frame_start_q <= fetch_valid_q && (fetch_x_q == '0) && (fetch_y_q == '0);
            line_start_q  <= fetch_valid_q && (fetch_x_q == '0);
        end
    end

    assign vid.fetchValid = fetch_valid_q;
    assign vid.fetchX     = fetch_x_q;
    assign vid.fetchY     = fetch_y_q;
    assign vid.activeArea = active_q;
    assign vid.hsync      = hsync_q;
    assign vid.vsync      = vsync_q;
    assign vid.frameStart = frame_start_q;
    assign vid.lineStart  = line_start_q;
endmodule
